// File: rtl/mips32_prog_loader.sv
// Framed byte-stream program loader for the mips32 core: loads memory words, releases the core,
// waits for HLT and, when PROG_LOADER_DUMP_EN is defined, streams R0..R(DUMP_REGS-1) out as bytes.
module mips32_prog_loader #(
  parameter int ADDR_W    = 10,
  parameter int DUMP_REGS = 6
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              cpu_start,
  input  logic              cpu_halted,
  output logic [4:0]        reg_raddr,
  input  logic [31:0]       reg_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              err
);

  localparam logic [7:0] SYNC = 8'hA5;

  typedef enum logic [3:0] {
    IDLE,
    ADDR_H,
    ADDR_L,
    CNT_H,
    CNT_L,
    DATA,
    START,
    RUN
`ifdef PROG_LOADER_DUMP_EN
    , DUMP
`endif
  } state_t;

  state_t            state_reg, state_next;
  logic [7:0]        hi_reg, hi_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [15:0]       count_reg, count_next;
  logic [1:0]        byte_cnt_reg, byte_cnt_next;
  logic [31:0]       asm_reg, asm_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [31:0]       mem_wdata_reg, mem_wdata_next;
  logic              hold_reg, hold_next;
  logic              fire_reg, fire_next;
  logic              err_reg, err_next;
  logic              rx_take;
  logic [15:0]       rx_pair;

`ifdef PROG_LOADER_DUMP_EN
  localparam logic [4:0] LAST_REG = 5'(DUMP_REGS - 1);

  logic [31:0] word_reg, word_next;
  logic [1:0]  tx_cnt_reg, tx_cnt_next;
  logic        tx_valid_reg, tx_valid_next;
  logic [4:0]  reg_idx_reg, reg_idx_next;
`else
  logic unused_dump_inputs;
  assign unused_dump_inputs = ^{reg_rdata, tx_ready};
`endif

  assign rx_ready = (state_reg == IDLE) || (state_reg == ADDR_H) || (state_reg == ADDR_L) ||
                    (state_reg == CNT_H) || (state_reg == CNT_L) || (state_reg == DATA);
  assign rx_take  = rx_valid && rx_ready;
  assign rx_pair  = {hi_reg, rx_data};

  always_comb begin
    state_next     = state_reg;
    hi_next        = hi_reg;
    addr_next      = addr_reg;
    count_next     = count_reg;
    byte_cnt_next  = byte_cnt_reg;
    asm_next       = asm_reg;
    mem_we_next    = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    hold_next      = hold_reg;
    fire_next      = 1'b0;
    err_next       = 1'b0;
`ifdef PROG_LOADER_DUMP_EN
    word_next      = word_reg;
    tx_cnt_next    = tx_cnt_reg;
    tx_valid_next  = tx_valid_reg;
    reg_idx_next   = reg_idx_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (rx_take) begin
          if (rx_data == SYNC) begin
            state_next = ADDR_H;
            hold_next  = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      ADDR_H: begin
        if (rx_take) begin
          hi_next    = rx_data;
          state_next = ADDR_L;
        end
      end
      ADDR_L: begin
        if (rx_take) begin
          addr_next  = ADDR_W'(rx_pair);
          state_next = CNT_H;
        end
      end
      CNT_H: begin
        if (rx_take) begin
          hi_next    = rx_data;
          state_next = CNT_L;
        end
      end
      CNT_L: begin
        if (rx_take) begin
          count_next    = rx_pair;
          byte_cnt_next = 2'd0;
          state_next    = (rx_pair == 16'd0) ? START : DATA;
        end
      end
      DATA: begin
        if (rx_take) begin
          asm_next      = {asm_reg[23:0], rx_data};
          byte_cnt_next = byte_cnt_reg + 2'd1;
          if (byte_cnt_reg == 2'd3) begin
            mem_we_next    = 1'b1;
            mem_addr_next  = addr_reg;
            mem_wdata_next = {asm_reg[23:0], rx_data};
            addr_next      = addr_reg + 1'b1;
            count_next     = count_reg - 16'd1;
            if (count_reg == 16'd1) begin
              state_next = START;
            end
          end
        end
      end
      START: begin
        // First cycle overlaps the final write strobe; the core is released on the second.
        if (!fire_reg) begin
          fire_next = 1'b1;
          hold_next = 1'b0;
        end else begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (cpu_halted) begin
`ifdef PROG_LOADER_DUMP_EN
          state_next    = DUMP;
          word_next     = reg_rdata;
          tx_cnt_next   = 2'd0;
          tx_valid_next = 1'b1;
`else
          state_next = IDLE;
`endif
        end
      end
`ifdef PROG_LOADER_DUMP_EN
      DUMP: begin
        if (tx_valid_reg) begin
          if (tx_ready) begin
            word_next   = {word_reg[23:0], 8'h00};
            tx_cnt_next = tx_cnt_reg + 2'd1;
            if (tx_cnt_reg == 2'd3) begin
              tx_valid_next = 1'b0;
              if (reg_idx_reg == LAST_REG) begin
                reg_idx_next = 5'd0;
                state_next   = IDLE;
              end else begin
                reg_idx_next = reg_idx_reg + 5'd1;
              end
            end
          end
        end else begin
          // Capture cycle: reg_raddr already points at the next register.
          word_next     = reg_rdata;
          tx_cnt_next   = 2'd0;
          tx_valid_next = 1'b1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      hi_reg        <= 8'h00;
      addr_reg      <= '0;
      count_reg     <= 16'd0;
      byte_cnt_reg  <= 2'd0;
      asm_reg       <= 32'd0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= 32'd0;
      hold_reg      <= 1'b1;
      fire_reg      <= 1'b0;
      err_reg       <= 1'b0;
`ifdef PROG_LOADER_DUMP_EN
      word_reg      <= 32'd0;
      tx_cnt_reg    <= 2'd0;
      tx_valid_reg  <= 1'b0;
      reg_idx_reg   <= 5'd0;
`endif
    end else begin
      state_reg     <= state_next;
      hi_reg        <= hi_next;
      addr_reg      <= addr_next;
      count_reg     <= count_next;
      byte_cnt_reg  <= byte_cnt_next;
      asm_reg       <= asm_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      hold_reg      <= hold_next;
      fire_reg      <= fire_next;
      err_reg       <= err_next;
`ifdef PROG_LOADER_DUMP_EN
      word_reg      <= word_next;
      tx_cnt_reg    <= tx_cnt_next;
      tx_valid_reg  <= tx_valid_next;
      reg_idx_reg   <= reg_idx_next;
`endif
    end
  end

  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign cpu_hold  = hold_reg;
  assign cpu_start = (state_reg == START) && fire_reg;
  assign busy      = (state_reg != IDLE);
  assign err       = err_reg;

`ifdef PROG_LOADER_DUMP_EN
  assign reg_raddr = reg_idx_reg;
  assign tx_data   = word_reg[31:24];
  assign tx_valid  = tx_valid_reg;
`else
  assign reg_raddr = 5'd0;
  assign tx_data   = 8'h00;
  assign tx_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed bench for mips32_prog_loader: frame loading, start timing, address wrap,
// error bytes, mid-frame reset and (with PROG_LOADER_DUMP_EN) the register dump.
module tb_mips32_prog_loader;
  localparam int ADDR_W    = 10;
  localparam int DUMP_REGS = 6;

  logic              clk1 = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              cpu_start;
  logic              cpu_halted = 1'b0;
  logic [4:0]        reg_raddr;
  logic [31:0]       reg_rdata;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b1;
  logic              busy;
  logic              err;

  logic [31:0] regs [32];
  assign reg_rdata = regs[reg_raddr];

  mips32_prog_loader #(.ADDR_W(ADDR_W), .DUMP_REGS(DUMP_REGS)) dut (
    .clk1(clk1), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .cpu_start(cpu_start), .cpu_halted(cpu_halted),
    .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .err(err)
  );

  always #5 clk1 = ~clk1;

  int total = 0;
  int bad   = 0;

  // Event log sampled on the falling edge, read by the tests at quiet points.
  int              cyc = 0, wr_n = 0, start_n = 0, start_cyc = 0, err_n = 0, tx_n = 0, stall_bad = 0;
  logic [ADDR_W-1:0] wr_addr [64];
  logic [31:0]     wr_data [64];
  int              wr_cyc  [64];
  logic [7:0]      tx_bytes [128];
  logic            prev_valid = 1'b0, prev_ready = 1'b0;
  logic [7:0]      prev_data = 8'h00;

  always @(negedge clk1) begin
    cyc <= cyc + 1;
    if (mem_we && wr_n < 64) begin
      wr_addr[wr_n] <= mem_addr;
      wr_data[wr_n] <= mem_wdata;
      wr_cyc[wr_n]  <= cyc;
      wr_n          <= wr_n + 1;
    end
    if (cpu_start) begin
      start_n   <= start_n + 1;
      start_cyc <= cyc;
    end
    if (err) err_n <= err_n + 1;
    if (tx_valid && tx_ready && tx_n < 128) begin
      tx_bytes[tx_n] <= tx_data;
      tx_n           <= tx_n + 1;
    end
    if (prev_valid && !prev_ready && (!tx_valid || tx_data !== prev_data)) stall_bad <= stall_bad + 1;
    prev_valid <= tx_valid;
    prev_ready <= tx_ready;
    prev_data  <= tx_data;
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk1);
    rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] base, input logic [15:0] n);
    send_byte(8'hA5);
    send_byte(base[15:8]);
    send_byte(base[7:0]);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  // Core model: clears HALTED on cpu_start, raises it 20 cycles later, then waits for IDLE.
  task automatic run_core(input bit stall);
    int k;
    k = 0;
    while (k < 60 && cpu_start !== 1'b1) begin
      @(negedge clk1);
      k++;
    end
    total++;
    if (cpu_start !== 1'b1) begin
      bad++;
      $display("FAIL start_seen: cpu_start=%b after %0d cycles, need 1", cpu_start, k);
    end
    cpu_halted = 1'b0;
    @(posedge clk1);
    #1;
    total++;
    if (rx_ready !== 1'b0 || cpu_hold !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL run_state: rx_ready=%b cpu_hold=%b busy=%b, need 0 0 1", rx_ready, cpu_hold, busy);
    end
    repeat (19) @(posedge clk1);
    #1;
    cpu_halted = 1'b1;
    k = 0;
    while (k < 400 && busy === 1'b1) begin
      @(posedge clk1);
      #1;
      if (stall) tx_ready = 1'($urandom_range(0, 1));
      k++;
    end
    tx_ready = 1'b1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL back_to_idle: busy=%b after %0d cycles, need 0", busy, k);
    end
    @(negedge clk1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk1);
    total++;
    if ({rx_ready, mem_we, cpu_hold, cpu_start, tx_valid, busy, err} !== 7'b1010000) begin
      bad++;
      $display("FAIL reset_ctrl: rdy,we,hold,start,txv,busy,err=%b need 1010000",
               {rx_ready, mem_we, cpu_hold, cpu_start, tx_valid, busy, err});
    end
    total++;
    if (mem_addr !== 10'h000 || mem_wdata !== 32'h0 || reg_raddr !== 5'd0 || tx_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_data: addr=%h wdata=%h raddr=%h tx=%h need all 0", mem_addr, mem_wdata, reg_raddr, tx_data);
    end
    rst_n = 1'b1;
    @(negedge clk1);
  endtask

  task automatic test_load_and_dump(input bit stall);
    int w0, s0, t0, sb0;
    logic [31:0] r;
    logic [7:0] expb;
    w0 = wr_n; s0 = start_n; t0 = tx_n; sb0 = stall_bad;
    send_hdr(16'h0000, 16'h0003);
    send_word(32'h2801000A);
    send_word(32'h28020014);
    send_word(32'h28030019);
    run_core(stall);
    total++;
    if (wr_n - w0 !== 3) begin
      bad++;
      $display("FAIL load_count: writes=%0d need 3", wr_n - w0);
    end else begin
      total++;
      if (wr_addr[w0] !== 10'h000 || wr_addr[w0+1] !== 10'h001 || wr_addr[w0+2] !== 10'h002) begin
        bad++;
        $display("FAIL load_addr: %h %h %h need 000 001 002", wr_addr[w0], wr_addr[w0+1], wr_addr[w0+2]);
      end
      total++;
      if (wr_data[w0] !== 32'h2801000A || wr_data[w0+1] !== 32'h28020014 || wr_data[w0+2] !== 32'h28030019) begin
        bad++;
        $display("FAIL load_data: %h %h %h need 2801000a 28020014 28030019", wr_data[w0], wr_data[w0+1], wr_data[w0+2]);
      end
      total++;
      if (wr_cyc[w0+1] - wr_cyc[w0] !== 4 || wr_cyc[w0+2] - wr_cyc[w0+1] !== 4) begin
        bad++;
        $display("FAIL load_rate: write gaps %0d %0d need 4 4", wr_cyc[w0+1] - wr_cyc[w0], wr_cyc[w0+2] - wr_cyc[w0+1]);
      end
      total++;
      if (start_cyc - wr_cyc[w0+2] !== 1) begin
        bad++;
        $display("FAIL start_timing: start-lastwrite=%0d cycles need 1", start_cyc - wr_cyc[w0+2]);
      end
    end
    total++;
    if (start_n - s0 !== 1) begin
      bad++;
      $display("FAIL start_count: pulses=%0d need 1", start_n - s0);
    end
`ifdef PROG_LOADER_DUMP_EN
    total++;
    if (tx_n - t0 !== 4 * DUMP_REGS) begin
      bad++;
      $display("FAIL dump_count: bytes=%0d need %0d", tx_n - t0, 4 * DUMP_REGS);
    end else begin
      total++;
      if (tx_bytes[t0+4] !== 8'h00 || tx_bytes[t0+5] !== 8'h00 || tx_bytes[t0+6] !== 8'h00 || tx_bytes[t0+7] !== 8'h0A) begin
        bad++;
        $display("FAIL dump_r1: %h %h %h %h need 00 00 00 0a", tx_bytes[t0+4], tx_bytes[t0+5], tx_bytes[t0+6], tx_bytes[t0+7]);
      end
      for (int i = 0; i < 4 * DUMP_REGS; i++) begin
        r = regs[i / 4];
        expb = r[31 - 8 * (i % 4) -: 8];
        total++;
        if (tx_bytes[t0+i] !== expb) begin
          bad++;
          $display("FAIL dump_byte%0d: got %h need %h", i, tx_bytes[t0+i], expb);
        end
      end
    end
    total++;
    if (stall_bad - sb0 !== 0) begin
      bad++;
      $display("FAIL dump_stall: %0d cycles changed or dropped a stalled byte, need 0", stall_bad - sb0);
    end
`else
    total++;
    if (tx_n - t0 !== 0 || tx_valid !== 1'b0 || reg_raddr !== 5'd0) begin
      bad++;
      $display("FAIL no_dump: bytes=%0d tx_valid=%b raddr=%h need 0 0 0", tx_n - t0, tx_valid, reg_raddr);
    end
`endif
  endtask

  task automatic test_err_and_empty();
    int e0, w0, s0;
    e0 = err_n; w0 = wr_n; s0 = start_n;
    send_byte(8'h55);
    repeat (2) @(negedge clk1);
    total++;
    if (err_n - e0 !== 1) begin
      bad++;
      $display("FAIL err_pulse: err high %0d cycles need 1", err_n - e0);
    end
    total++;
    if (busy !== 1'b0 || rx_ready !== 1'b1) begin
      bad++;
      $display("FAIL err_idle: busy=%b rx_ready=%b need 0 1", busy, rx_ready);
    end
    send_hdr(16'h0123, 16'h0000);
    run_core(1'b0);
    total++;
    if (start_n - s0 !== 1 || wr_n - w0 !== 0) begin
      bad++;
      $display("FAIL empty_frame: starts=%0d writes=%0d need 1 0", start_n - s0, wr_n - w0);
    end
  endtask

  task automatic test_addr_wrap();
    int w0;
    w0 = wr_n;
    send_hdr(16'h03FF, 16'h0002);
    send_word(32'h01020304);
    send_word(32'hA0B0C0D0);
    run_core(1'b0);
    total++;
    if (wr_n - w0 !== 2 || wr_addr[w0] !== 10'h3FF || wr_addr[w0+1] !== 10'h000) begin
      bad++;
      $display("FAIL wrap_addr: n=%0d addr %h %h need 2 3ff 000", wr_n - w0, wr_addr[w0], wr_addr[w0+1]);
    end
    total++;
    if (wr_data[w0] !== 32'h01020304 || wr_data[w0+1] !== 32'hA0B0C0D0) begin
      bad++;
      $display("FAIL wrap_data: %h %h need 01020304 a0b0c0d0", wr_data[w0], wr_data[w0+1]);
    end
  endtask

  task automatic test_reset_mid_word();
    int w0, s0;
    w0 = wr_n; s0 = start_n;
    send_hdr(16'h0010, 16'h0002);
    send_word(32'h11223344);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst_n = 1'b0;
    @(negedge clk1);
    total++;
    if ({rx_ready, mem_we, cpu_hold, cpu_start, tx_valid, busy, err} !== 7'b1010000 ||
        mem_addr !== 10'h000 || mem_wdata !== 32'h0 || tx_data !== 8'h00 || reg_raddr !== 5'd0) begin
      bad++;
      $display("FAIL midreset_outputs: ctrl=%b addr=%h wdata=%h tx=%h need 1010000 000 0 00",
               {rx_ready, mem_we, cpu_hold, cpu_start, tx_valid, busy, err}, mem_addr, mem_wdata, tx_data);
    end
    rst_n = 1'b1;
    repeat (6) @(negedge clk1);
    total++;
    if (wr_n - w0 !== 1 || start_n - s0 !== 0) begin
      bad++;
      $display("FAIL midreset_writes: writes=%0d starts=%0d need 1 0", wr_n - w0, start_n - s0);
    end
    w0 = wr_n;
    send_hdr(16'h0020, 16'h0001);
    send_word(32'hDEADBEEF);
    run_core(1'b0);
    total++;
    if (wr_n - w0 !== 1 || wr_addr[w0] !== 10'h020 || wr_data[w0] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL reload: n=%0d addr=%h data=%h need 1 020 deadbeef", wr_n - w0, wr_addr[w0], wr_data[w0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    regs[1] = 32'h0000000A;
    regs[2] = 32'h00000014;
    regs[3] = 32'h00000019;
    regs[4] = 32'h12345678;
    regs[5] = 32'hCAFEF00D;
    test_reset();
    test_load_and_dump(1'b0);
`ifdef PROG_LOADER_DUMP_EN
    test_load_and_dump(1'b1);
`endif
    test_err_and_empty();
    test_addr_wrap();
    test_reset_mid_word();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
